// File: rtl/loader_pkg.sv
// ============================================================================
// Module  : loader_pkg
// Brief   : Shared state encoding and width defaults for the program loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  localparam int LOADER_D = 12;
  localparam int LOADER_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that saturates at a run-time limit; clear has priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count  = r_count;
  assign at_max = w_at_max;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module  : prog_loader
// Brief   : Streams machine code into instruction memory, starts the core and
//           times the run until done or timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import loader_pkg::*;
#(
  parameter int D         = LOADER_D,
  parameter int W         = LOADER_W,
  parameter int START_CYC = 2,
  parameter int MAX_CYC   = 65535,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          imem_wr_en,
  output logic [D-1:0]  imem_wr_addr,
  output logic [W-1:0]  imem_wr_data,
  output logic          start,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  input  logic          ack,
  output logic [CW-1:0] cycle_count,
  output logic          err_ovf,
  output logic          err_tmo
);

  localparam int SW = $clog2(START_CYC + 1);

  loader_state_t r_state;
  logic [D-1:0]  r_addr;
  logic          r_ready;
  logic          r_wr_en;
  logic [D-1:0]  r_wr_addr;
  logic [W-1:0]  r_wr_data;
  logic          r_start;
  logic          r_busy;
  logic          r_run_done;
  logic          r_err_ovf;
  logic          r_err_tmo;

  logic          w_accept;
  logic          w_last;
  logic          w_hold_at_max;
  logic          w_cyc_at_max;
  logic [SW-1:0] w_hold_cnt_unused;

  assign w_accept = in_valid && r_ready;
  // The top address is forced to be the final word so the address never wraps.
  assign w_last   = in_last || (&r_addr);

  sat_counter #(.WIDTH(SW)) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (r_state != ST_START),
    .en     (r_state == ST_START),
    .max    (SW'(START_CYC - 1)),
    .count  (w_hold_cnt_unused),
    .at_max (w_hold_at_max)
  );

  sat_counter #(.WIDTH(CW)) u_cycle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_accept && (r_state == ST_IDLE)),
    .en     ((r_state == ST_RUN) && !core_done),
    .max    (CW'(MAX_CYC)),
    .count  (cycle_count),
    .at_max (w_cyc_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_ready    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_run_done <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_addr;
        r_wr_data <= in_data;
      end

      case (r_state)
        ST_IDLE, ST_LOAD: begin
          r_ready <= !(w_accept && w_last);
          if (w_accept) begin
            r_busy <= 1'b1;
            if (r_state == ST_IDLE) begin
              r_err_ovf <= 1'b0;
              r_err_tmo <= 1'b0;
            end
            if (w_last) begin
              r_state <= ST_START;
              r_start <= 1'b1;
              r_addr  <= '0;
              if (!in_last) begin
                r_err_ovf <= 1'b1;
              end
            end else begin
              r_state <= ST_LOAD;
              r_addr  <= r_addr + D'(1);
            end
          end
        end

        ST_START: begin
          if (w_hold_at_max) begin
            r_state <= ST_RUN;
            r_start <= 1'b0;
          end
        end

        ST_RUN: begin
          // core_done takes priority over a coincident timeout.
          if (core_done) begin
            r_state    <= ST_DONE;
            r_run_done <= 1'b1;
            r_busy     <= 1'b0;
          end else if (w_cyc_at_max) begin
            r_state    <= ST_DONE;
            r_run_done <= 1'b1;
            r_busy     <= 1'b0;
            r_err_tmo  <= 1'b1;
          end
        end

        ST_DONE: begin
          if (ack) begin
            r_state    <= ST_IDLE;
            r_run_done <= 1'b0;
            r_ready    <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign start        = r_start;
  assign busy         = r_busy;
  assign run_done     = r_run_done;
  assign err_ovf      = r_err_ovf;
  assign err_tmo      = r_err_tmo;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader: vector table, random programs
//           against a transaction-level model, and reset corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int D    = 3;
  localparam int W    = 9;
  localparam int SC   = 2;
  localparam int MAXC = 100;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          imem_wr_en;
  logic [D-1:0]  imem_wr_addr;
  logic [W-1:0]  imem_wr_data;
  logic          start;
  logic          core_done;
  logic          busy;
  logic          run_done;
  logic          ack;
  logic [CW-1:0] cycle_count;
  logic          err_ovf;
  logic          err_tmo;

  int n_checks = 0;
  int n_errors = 0;

  logic [D+W-1:0] wq[$];

  typedef struct {
    int n;
    bit last;
    int gap;
    int delay;
    int exp_cnt;
    bit exp_tmo;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[7];

  prog_loader #(
    .D(D), .W(W), .START_CYC(SC), .MAX_CYC(MAXC), .CW(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .start        (start),
    .core_done    (core_done),
    .busy         (busy),
    .run_done     (run_done),
    .ack          (ack),
    .cycle_count  (cycle_count),
    .err_ovf      (err_ovf),
    .err_tmo      (err_tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && imem_wr_en) wq.push_back({imem_wr_addr, imem_wr_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run outcome from the rules: done wins up to and including MAX, else timeout.
  function automatic void model_run(input int delay, output int cnt, output bit tmo);
    if (delay < 0 || delay > MAXC) begin
      cnt = MAXC;
      tmo = 1'b1;
    end else begin
      cnt = delay;
      tmo = 1'b0;
    end
  endfunction

  task automatic load_prog(input int n, input bit has_last, input int gap,
                           input logic [W-1:0] base, input bit rnd_ack);
    for (int i = 0; i < n; i++) begin
      int waited;
      logic [W-1:0] exp_d;
      waited   = 0;
      exp_d    = base + W'(i);
      in_valid = 1'b1;
      in_data  = exp_d;
      in_last  = has_last && (i == n - 1);
      if (rnd_ack) ack = 1'($urandom);
      while (!in_ready && waited < 20) begin
        step();
        waited++;
      end
      if (!in_ready) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ack      = 1'b0;
        return;
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      ack      = 1'b0;
      if (i == 0) begin
        check("clr_count", cycle_count, 0);
        check("clr_ovf", err_ovf, 0);
        check("clr_tmo", err_tmo, 0);
      end
      check("wr_en", imem_wr_en, 1);
      check("wr_addr", imem_wr_addr, i);
      check("wr_data", imem_wr_data, exp_d);
      if (i != n - 1) repeat (gap) step();
    end
  endtask

  task automatic run_check(input int n, input logic [W-1:0] base, input int delay,
                           input int exp_cnt, input bit exp_tmo, input bit exp_ovf);
    int sc;
    int w;
    logic [D+W-1:0] e;
    check("start_first", start, 1);
    check("ready_low", in_ready, 0);
    check("busy_start", busy, 1);
    sc = 0;
    while (start && sc < 10) begin
      step();
      sc++;
    end
    check("start_len", sc, SC);
    if (delay >= 0) begin
      repeat (delay) step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
    end
    w = 0;
    while (!run_done && w < MAXC + 20) begin
      step();
      w++;
    end
    check("run_done", run_done, 1);
    if (delay >= 0 && delay <= MAXC) check("done_lat", w, 0);
    if (delay < 0) check("tmo_lat", w, MAXC + 1);
    check("cycle_count", cycle_count, exp_cnt);
    check("err_tmo", err_tmo, exp_tmo);
    check("err_ovf", err_ovf, exp_ovf);
    check("busy_done", busy, 0);
    repeat ($urandom_range(0, 2)) step();
    check("done_hold", run_done, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_drop", run_done, 0);
    check("idle_ready", in_ready, 1);
    check("keep_cnt", cycle_count, exp_cnt);
    check("keep_tmo", err_tmo, exp_tmo);
    check("keep_ovf", err_ovf, exp_ovf);
    check("n_writes", wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++) begin
      e = {D'(k), base + W'(k)};
      check("wq_entry", wq[k], e);
    end
  endtask

  task automatic do_reset_pulse();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [W-1:0] base;
    int n, gap, delay, cnt, wt;
    bit last, tmo;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    core_done = 1'b0; ack = 1'b0;

    vecs[0] = '{5, 1'b1, 0, 37, 37, 1'b0, 1'b0};
    vecs[1] = '{4, 1'b1, 1, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{1, 1'b1, 0, 5, 5, 1'b0, 1'b0};
    vecs[3] = '{8, 1'b0, 0, 3, 3, 1'b0, 1'b1};
    vecs[4] = '{3, 1'b1, 0, -1, 100, 1'b1, 1'b0};
    vecs[5] = '{8, 1'b1, 1, 100, 100, 1'b0, 1'b0};
    vecs[6] = '{2, 1'b1, 0, 99, 99, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_wr", {imem_wr_en, imem_wr_addr, imem_wr_data}, 0);
    check("rst_ctl", {start, busy, run_done, err_ovf, err_tmo}, 0);
    check("rst_cnt", cycle_count, 0);
    do_reset_pulse();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      base = (i == 0) ? 9'h1C0 : W'($urandom_range(0, 511));
      wq.delete();
      load_prog(vecs[i].n, vecs[i].last, vecs[i].gap, base, 1'b0);
      run_check(vecs[i].n, base, vecs[i].delay, vecs[i].exp_cnt, vecs[i].exp_tmo, vecs[i].exp_ovf);
    end

    for (int r = 0; r < 12; r++) begin
      n     = $urandom_range(1, 8);
      last  = (n < 8) ? 1'b1 : 1'($urandom);
      gap   = $urandom_range(0, 2);
      delay = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 110);
      base  = W'($urandom_range(0, 511));
      model_run(delay, cnt, tmo);
      wq.delete();
      load_prog(n, last, gap, base, 1'b1);
      run_check(n, base, delay, cnt, tmo, !last);
    end

    // Reset while loading: partial program abandoned, next load from address 0.
    wq.delete();
    load_prog(3, 1'b0, 0, 9'h0A0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rl_ready", in_ready, 0);
    check("rl_wr", {imem_wr_en, imem_wr_addr, imem_wr_data}, 0);
    check("rl_busy", busy, 0);
    do_reset_pulse();
    check("rl_ready_back", in_ready, 1);
    wq.delete();
    load_prog(2, 1'b1, 0, 9'h055, 1'b0);
    run_check(2, 9'h055, 4, 4, 1'b0, 1'b0);

    // Reset during START drops start asynchronously.
    load_prog(1, 1'b1, 0, 9'h011, 1'b0);
    check("rs_start_pre", start, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_start", start, 0);
    check("rs_busy", busy, 0);
    do_reset_pulse();

    // Reset during RUN.
    load_prog(2, 1'b1, 0, 9'h123, 1'b0);
    wt = 0;
    while (start && wt < 10) begin
      step();
      wt++;
    end
    repeat (10) step();
    check("rr_busy_pre", busy, 1);
    check("rr_cnt_pre", cycle_count, 10);
    #2 rst_n = 1'b0;
    #1;
    check("rr_cnt", cycle_count, 0);
    check("rr_ctl", {busy, run_done, start, in_ready}, 0);
    do_reset_pulse();
    wq.delete();
    load_prog(3, 1'b1, 1, 9'h1FE, 1'b0);
    run_check(3, 9'h1FE, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Upstream front-end for `top_level`. Accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them into the writable port of the instruction memory. It then drives the core's `start` for a fixed number of cycles and counts execution cycles until the core raises `done`. It reports completion, cycle count and error flags to the host and holds them until acknowledged.

## Interface
Parameters:
- `D`, 12, instruction-memory address / program-counter width
- `W`, 9, machine-code word width
- `START_CYC`, 2, number of cycles `start` is held high (≥1)
- `MAX_CYC`, 65535, run-cycle limit before timeout; must fit in `CW`
- `CW`, 16, cycle-counter width

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  host word valid
- `in_ready`  out  1  loader can accept a word
- `in_data`  in  W  machine-code word
- `in_last`  in  1  marks final word of program
- `imem_wr_en`  out  1  instruction-memory write strobe
- `imem_wr_addr`  out  D  write address
- `imem_wr_data`  out  W  write data
- `start`  out  1  to core `start`
- `core_done`  in  1  from core `done`
- `busy`  out  1  high in LOAD, START, RUN
- `run_done`  out  1  result valid, held until `ack`
- `ack`  in  1  host acknowledges result
- `cycle_count`  out  CW  cycles spent in RUN
- `err_ovf`  out  1  program filled memory without `in_last`
- `err_tmo`  out  1  run hit `MAX_CYC`

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- Handshake: a word is accepted when `in_valid && in_ready`. `in_ready` is 1 in IDLE and LOAD only. The host may hold `in_valid` across ready-low cycles without data loss.
- IDLE: the first accepted word clears `err_ovf`, `err_tmo` and `cycle_count`, is written at address 0, and moves the FSM to LOAD, or to START if `in_last` is set.
- LOAD: each accepted word is written at the next address (0,1,2,...). Accepting a word with `in_last` → START.
- Overflow: a word accepted at address 2^D−1 without `in_last` is written, treated as last, and sets `err_ovf`; FSM → START. The address never wraps.
- START: `start`=1 for exactly `START_CYC` cycles, then → RUN. The write address resets to 0.
- RUN: `cycle_count` increments every cycle.
  - `core_done` sampled 1 → DONE; the count excludes that cycle.
  - `cycle_count` reaching `MAX_CYC` with `core_done` still 0 → DONE with `err_tmo`=1.
  - If both happen in the same cycle, `core_done` wins and `err_tmo` stays 0.
- DONE: `run_done`=1; `cycle_count` and flags frozen. `ack`=1 → IDLE; `run_done` drops the next cycle. `ack` outside DONE is ignored.
- Flags and `cycle_count` remain readable in IDLE until the next program's first accepted word.

## Timing
- Reset values: `in_ready`=0 during reset, 1 in the first cycle after release (IDLE). All other outputs are 0, the write address is 0, and the FSM is IDLE.
- Write latency: the `imem_wr_*` outputs are registered and asserted exactly one cycle after acceptance, for one cycle. Back-to-back accepts give back-to-back writes.
- Last-word write coincides with the first `start` cycle. `start` is high for cycles k+1..k+`START_CYC`, where k is the accept cycle of the last word.
- RUN begins the cycle after `start` falls. Minimum RUN→DONE latency is 1 cycle, in which case `cycle_count`=0.
- Reset mid-operation: immediate return to reset values. Any partial program is abandoned and `start` drops asynchronously.

## Structure
- Shared package `loader_pkg`: the `loader_state_t` enum (IDLE, LOAD, START, RUN, DONE) and the defaults for `W` and `D`.
- One sub-module, `sat_counter`, parameterised by width with `clr`/`en`/`max` inputs and an `at_max` output. It is instantiated for the `START_CYC` hold count and for `cycle_count`.
- The FSM, address register and write-port registers live in `prog_loader`.

## Test plan
- Load 5 words (0x1C0..0x1C4, `in_last` on the 5th) back-to-back → writes to addresses 0..4 with matching data one cycle after each accept; `start` high 2 cycles; `in_ready`=0 from the cycle after the last accept.
- `in_valid` toggling every other cycle during load → no words dropped or duplicated; addresses remain contiguous.
- Drive `core_done` high 37 cycles after RUN entry → `run_done`=1, `cycle_count`=37, both flags 0; `ack` → IDLE; values persist until the next accepted word clears them.
- Never assert `core_done`, `MAX_CYC`=100 → DONE with `err_tmo`=1 and `cycle_count`=100.
- With D=3, stream 8 words without `in_last` → addresses 0..7 written, `err_ovf`=1, START entered with no wrap.
- Deassert `rst_n` during RUN and during LOAD → all outputs at reset values the same cycle; the next program loads from address 0.
